// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator: standard mode timings,
// sync polarity encodings and the per-axis total helper.
package vga_timing_pkg;

   localparam int POL_POS = 1;
   localparam int POL_NEG = 0;

   // 640x480@60, totals 800 x 525
   localparam int M640_H_ACTIVE = 640;
   localparam int M640_H_FP     = 16;
   localparam int M640_H_SYNC   = 96;
   localparam int M640_H_BP     = 48;
   localparam int M640_V_ACTIVE = 480;
   localparam int M640_V_FP     = 10;
   localparam int M640_V_SYNC   = 2;
   localparam int M640_V_BP     = 33;

   // 800x600@60, totals 1056 x 628
   localparam int M800_H_ACTIVE = 800;
   localparam int M800_H_FP     = 40;
   localparam int M800_H_SYNC   = 128;
   localparam int M800_H_BP     = 88;
   localparam int M800_V_ACTIVE = 600;
   localparam int M800_V_FP     = 1;
   localparam int M800_V_SYNC   = 4;
   localparam int M800_V_BP     = 23;

   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video output bundle of the timing generator: syncs, display enable,
// coordinates, strobes, frame counter and test-pattern RGB.
interface vga_timing_gen_if #(
   parameter int CW      = 12,
   parameter int FRAME_W = 8
);
   logic               o_hsync;
   logic               o_vsync;
   logic               o_de;
   logic [CW-1:0]      o_x;
   logic [CW-1:0]      o_y;
   logic               o_line_start;
   logic               o_frame_start;
   logic [FRAME_W-1:0] o_frame_count;
   logic               o_red;
   logic               o_green;
   logic               o_blue;

   modport master (
      output o_hsync, o_vsync, o_de, o_x, o_y, o_line_start, o_frame_start,
             o_frame_count, o_red, o_green, o_blue
   );

   modport slave (
      input  o_hsync, o_vsync, o_de, o_x, o_y, o_line_start, o_frame_start,
             o_frame_count, o_red, o_green, o_blue
   );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrap counter over ACTIVE+FP+SYNC+BP positions with
// combinational wrap/active/sync decode of the current count.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = 800,
   parameter int FP     = 40,
   parameter int SYNC   = 128,
   parameter int BP     = 88,
   parameter int CW     = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          step,
   output logic [CW-1:0] count,
   output logic          wrap,
   output logic          active,
   output logic          sync_active
);

   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

   generate
      if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1 || CW < 1) begin : g_bad_param
         $error("vga_axis_counter: every timing parameter and CW must be >= 1");
      end
      if (longint'(TOTAL) > (longint'(1) << CW)) begin : g_bad_width
         $error("vga_axis_counter: axis total does not fit in CW bits");
      end
   endgenerate

   // All bounds stay below 2**CW because BP >= 1 keeps sync end under TOTAL.
   localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
   localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
   localparam logic [CW-1:0] SYNC_BEGIN = CW'(ACTIVE + FP);
   localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

   assign wrap        = (count == LAST);
   assign active      = (count < ACT_END);
   assign sync_active = (count >= SYNC_BEGIN) && (count < SYNC_END);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (step) begin
         count <= wrap ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a single registered output stage.
// Optional quadrant test pattern on RGB when VGA_TESTPATTERN_EN is defined.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE   = M800_H_ACTIVE,
   parameter int H_FP       = M800_H_FP,
   parameter int H_SYNC     = M800_H_SYNC,
   parameter int H_BP       = M800_H_BP,
   parameter int V_ACTIVE   = M800_V_ACTIVE,
   parameter int V_FP       = M800_V_FP,
   parameter int V_SYNC     = M800_V_SYNC,
   parameter int V_BP       = M800_V_BP,
   parameter int H_SYNC_POL = POL_POS,
   parameter int V_SYNC_POL = POL_POS,
   parameter int CW         = 12,
   parameter int FRAME_W    = 8
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic              i_enable,
   vga_timing_gen_if.master  vid
);

   generate
      if (FRAME_W < 1) begin : g_bad_frame_w
         $error("vga_timing_gen: FRAME_W must be >= 1");
      end
   endgenerate

   localparam logic H_ON = (H_SYNC_POL != 0);
   localparam logic V_ON = (V_SYNC_POL != 0);

   logic [CW-1:0]      h_count, v_count;
   logic               h_wrap, v_wrap, h_active, v_active, h_sync, v_sync;
   logic [FRAME_W-1:0] frame_cnt;
   logic               de_next;

   assign de_next = h_active && v_active;

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
   ) u_h_axis (
      .clk(i_clock), .rst_n(i_reset_n), .step(i_enable),
      .count(h_count), .wrap(h_wrap), .active(h_active), .sync_active(h_sync)
   );

   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
   ) u_v_axis (
      .clk(i_clock), .rst_n(i_reset_n), .step(i_enable && h_wrap),
      .count(v_count), .wrap(v_wrap), .active(v_active), .sync_active(v_sync)
   );

   // Counts on the v-wrap edge; the output copy lands with the next (0,0).
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         frame_cnt <= '0;
      end else if (i_enable && h_wrap && v_wrap) begin
         frame_cnt <= frame_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         vid.o_hsync       <= ~H_ON;
         vid.o_vsync       <= ~V_ON;
         vid.o_de          <= 1'b0;
         vid.o_x           <= '0;
         vid.o_y           <= '0;
         vid.o_line_start  <= 1'b0;
         vid.o_frame_start <= 1'b0;
         vid.o_frame_count <= '0;
      end else if (i_enable) begin
         vid.o_hsync       <= h_sync ? H_ON : ~H_ON;
         vid.o_vsync       <= v_sync ? V_ON : ~V_ON;
         vid.o_de          <= de_next;
         vid.o_x           <= h_count;
         vid.o_y           <= v_count;
         vid.o_line_start  <= (h_count == '0);
         vid.o_frame_start <= (h_count == '0) && (v_count == '0);
         vid.o_frame_count <= frame_cnt;
      end
   end

`ifdef VGA_TESTPATTERN_EN
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         vid.o_red   <= 1'b0;
         vid.o_green <= 1'b0;
         vid.o_blue  <= 1'b0;
      end else if (i_enable) begin
         vid.o_red   <= de_next;
         vid.o_green <= de_next && (h_count < CW'(H_ACTIVE / 2));
         vid.o_blue  <= de_next && (v_count < CW'(V_ACTIVE / 2));
      end
   end
`else
   assign vid.o_red   = 1'b0;
   assign vid.o_green = 1'b0;
   assign vid.o_blue  = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen in a 14x8 raster mode, positive and negative
// sync polarity instances side by side; RGB expectations follow VGA_TESTPATTERN_EN.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   localparam int HA = 8, HF = 2, HS = 3, HB = 1;
   localparam int VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int HT = 14, VT = 8;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;

   int tests = 0;
   int fails = 0;
   int mx = 0, my = 0, mframes = 0;

   always #5 clk = ~clk;

   vga_timing_gen_if #(.CW(CW), .FRAME_W(2)) vid_a ();
   vga_timing_gen_if #(.CW(CW), .FRAME_W(8)) vid_b ();

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_SYNC_POL(POL_POS), .V_SYNC_POL(POL_POS), .CW(CW), .FRAME_W(2)
   ) dut_a (
      .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .vid(vid_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_SYNC_POL(POL_NEG), .V_SYNC_POL(POL_NEG), .CW(CW), .FRAME_W(8)
   ) dut_b (
      .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .vid(vid_b)
   );

   wire [22:0] obs_a = {vid_a.o_x, vid_a.o_y, vid_a.o_de, vid_a.o_hsync, vid_a.o_vsync,
                        vid_a.o_line_start, vid_a.o_frame_start, vid_a.o_frame_count};
   wire [2:0]  obs_rgb = {vid_a.o_red, vid_a.o_green, vid_a.o_blue};
   wire [9:0]  obs_b = {vid_b.o_hsync, vid_b.o_vsync, vid_b.o_frame_count};

   // Expected decode, written from the raster windows: hsync x=10..12, vsync y=5..6.
   function automatic logic [22:0] model_a(input int x, input int y, input int f);
      logic de, hs, vs;
      de = (x < HA) && (y < VA);
      hs = (x >= 10) && (x <= 12);
      vs = (y >= 5) && (y <= 6);
      return {8'(x), 8'(y), de, hs, vs, (x == 0), (x == 0) && (y == 0), 2'(f % 4)};
   endfunction

   function automatic logic [9:0] model_b(input int x, input int y, input int f);
      logic hs, vs;
      hs = (x >= 10) && (x <= 12);
      vs = (y >= 5) && (y <= 6);
      return {~hs, ~vs, 8'(f % 256)};
   endfunction

   function automatic logic [2:0] model_rgb(input int x, input int y);
      logic de;
      de = (x < HA) && (y < VA);
`ifdef VGA_TESTPATTERN_EN
      return {de, de && (x < 4), de && (y < 2)};
`else
      return {1'b0, 1'b0, 1'b0} & {3{de}};
`endif
   endfunction

   task automatic model_step();
      mx++;
      if (mx == HT) begin
         mx = 0;
         my++;
         if (my == VT) begin
            my = 0;
            mframes++;
         end
      end
   endtask

   // Advances until the sample just taken is the model position (tx,ty).
   task automatic run_to(input int tx, input int ty, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (mx == tx && my == ty) begin
            ok = 1'b1;
            break;
         end
         model_step();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (obs_a !== 23'd0) begin
         fails++; $display("FAIL reset_a: got %h want %h", obs_a, 23'd0);
      end
      tests++;
      if (obs_b !== 10'b11_0000_0000) begin
         fails++; $display("FAIL reset_b_sync: got %h want %h", obs_b, 10'b11_0000_0000);
      end
      tests++;
      if (obs_rgb !== 3'b000) begin
         fails++; $display("FAIL reset_rgb: got %b want 000", obs_rgb);
      end
   endtask

   task automatic test_first_edge();
      @(negedge clk);
      rst_n = 1'b1;
      mx = 0; my = 0; mframes = 0;
      @(posedge clk); #1;
      tests++;
      if (obs_a !== model_a(0, 0, 0)) begin
         fails++; $display("FAIL first_edge: got %h want %h", obs_a, model_a(0, 0, 0));
      end
      tests++;
      if (obs_rgb !== model_rgb(0, 0)) begin
         fails++; $display("FAIL first_edge_rgb: got %b want %b", obs_rgb, model_rgb(0, 0));
      end
      model_step();
   endtask

   task automatic test_frames();
      logic [1:0] exp_q[$];
      int de_n = 0, fs_n = 0, ls_n = 0, hs_n = 0, vs_n = 0, bad = 0;
      exp_q = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      for (int i = 1; i <= 5 * HT * VT; i++) begin
         @(posedge clk); #1;
         tests++;
         if (obs_a !== model_a(mx, my, mframes)) begin
            fails++; bad++;
            if (bad < 10) $display("FAIL frame_decode (%0d,%0d): got %h want %h", mx, my, obs_a, model_a(mx, my, mframes));
         end
         tests++;
         if (obs_b !== model_b(mx, my, mframes)) begin
            fails++; bad++;
            if (bad < 10) $display("FAIL frame_neg_sync (%0d,%0d): got %h want %h", mx, my, obs_b, model_b(mx, my, mframes));
         end
         tests++;
         if (obs_rgb !== model_rgb(mx, my)) begin
            fails++; bad++;
            if (bad < 10) $display("FAIL frame_rgb (%0d,%0d): got %b want %b", mx, my, obs_rgb, model_rgb(mx, my));
         end
         if (i <= HT * VT) begin
            de_n += int'(vid_a.o_de);
            fs_n += int'(vid_a.o_frame_start);
            ls_n += int'(vid_a.o_line_start);
            hs_n += int'(vid_a.o_hsync);
            vs_n += int'(vid_a.o_vsync);
         end
         if (vid_a.o_frame_start === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++; $display("FAIL frame_count_extra: got %0d want none", vid_a.o_frame_count);
            end else if (vid_a.o_frame_count !== exp_q[0]) begin
               fails++; $display("FAIL frame_count_seq: got %0d want %0d", vid_a.o_frame_count, exp_q[0]);
               void'(exp_q.pop_front());
            end else begin
               void'(exp_q.pop_front());
            end
         end
         model_step();
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++; $display("FAIL frame_count_missing: got %0d left want 0", exp_q.size());
      end
      tests++;
      if (de_n != 32) begin
         fails++; $display("FAIL de_per_frame: got %0d want 32", de_n);
      end
      tests++;
      if (fs_n != 1) begin
         fails++; $display("FAIL frame_start_per_frame: got %0d want 1", fs_n);
      end
      tests++;
      if (ls_n != 8) begin
         fails++; $display("FAIL line_start_per_frame: got %0d want 8", ls_n);
      end
      tests++;
      if (hs_n != 24) begin
         fails++; $display("FAIL hsync_per_frame: got %0d want 24", hs_n);
      end
      tests++;
      if (vs_n != 28) begin
         fails++; $display("FAIL vsync_per_frame: got %0d want 28", vs_n);
      end
   endtask

   task automatic test_enable_freeze();
      bit ok;
      run_to(3, 2, ok);
      tests++;
      if (!ok) begin
         fails++; $display("FAIL freeze_reach: got timeout want (3,2)");
      end
      @(negedge clk);
      en = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         tests++;
         if (obs_a !== model_a(3, 2, mframes)) begin
            fails++; $display("FAIL freeze_hold: got %h want %h", obs_a, model_a(3, 2, mframes));
         end
      end
      @(negedge clk);
      en = 1'b1;
      model_step();
      @(posedge clk); #1;
      tests++;
      if (obs_a !== model_a(4, 2, mframes)) begin
         fails++; $display("FAIL freeze_resume: got %h want %h", obs_a, model_a(4, 2, mframes));
      end
      tests++;
      if (obs_rgb !== model_rgb(4, 2)) begin
         fails++; $display("FAIL rgb_4_2: got %b want %b", obs_rgb, model_rgb(4, 2));
      end
      model_step();
      run_to(0, 0, ok);
      tests++;
      if (!ok) begin
         fails++; $display("FAIL freeze_fs_reach: got timeout want (0,0)");
      end
      @(negedge clk);
      en = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         tests++;
         if (obs_a !== model_a(0, 0, mframes)) begin
            fails++; $display("FAIL freeze_strobe_hold: got %h want %h", obs_a, model_a(0, 0, mframes));
         end
      end
      @(negedge clk);
      en = 1'b1;
      model_step();
      @(posedge clk); #1;
      tests++;
      if (obs_a !== model_a(1, 0, mframes)) begin
         fails++; $display("FAIL freeze_fs_resume: got %h want %h", obs_a, model_a(1, 0, mframes));
      end
      model_step();
   endtask

   task automatic test_reset_mid();
      bit ok;
      run_to(9, 3, ok);
      tests++;
      if (!ok) begin
         fails++; $display("FAIL reset_mid_reach: got timeout want (9,3)");
      end
      tests++;
      if (obs_a !== model_a(9, 3, mframes)) begin
         fails++; $display("FAIL reset_mid_pre: got %h want %h", obs_a, model_a(9, 3, mframes));
      end
      #1;
      rst_n = 1'b0;
      #1;
      tests++;
      if (obs_a !== 23'd0) begin
         fails++; $display("FAIL reset_mid_async: got %h want %h", obs_a, 23'd0);
      end
      tests++;
      if (obs_b !== 10'b11_0000_0000) begin
         fails++; $display("FAIL reset_mid_b_sync: got %h want %h", obs_b, 10'b11_0000_0000);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mx = 0; my = 0; mframes = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         tests++;
         if (obs_a !== model_a(mx, my, mframes)) begin
            fails++; $display("FAIL reset_mid_restart (%0d,%0d): got %h want %h", mx, my, obs_a, model_a(mx, my, mframes));
         end
         model_step();
      end
   endtask

   initial begin
      test_reset();
      test_first_edge();
      test_frames();
      test_enable_freeze();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator: next generation of the team's fixed 800x600 sync generator.
- Per-axis timing, sync polarity and counter width are parameters.
- Outputs registered, mutually aligned sync/blank/coordinate signals, frame/line strobes, a frame counter and a clock-enable stall.
- Sits directly behind the pixel-clock PLL and drives the pixel source and the RGB/sync pins.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, horizontal sync width (clocks)
- H_BP, 88, horizontal back porch (clocks)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- H_SYNC_POL, 1, 1 = hsync active-high, 0 = active-low
- V_SYNC_POL, 1, 1 = vsync active-high, 0 = active-low
- CW, 12, coordinate counter width
- FRAME_W, 8, frame counter width

Ports:
- i_clock  in  1  pixel clock
- i_reset_n  in  1  asynchronous active-low reset
- i_enable  in  1  clock enable; low freezes all state
- o_hsync  out  1  horizontal sync, polarity per H_SYNC_POL
- o_vsync  out  1  vertical sync, polarity per V_SYNC_POL
- o_de  out  1  display enable (active area)
- o_x  out  CW  horizontal position, 0..H_TOTAL-1
- o_y  out  CW  vertical position, 0..V_TOTAL-1
- o_line_start  out  1  one-cycle strobe at x=0
- o_frame_start  out  1  one-cycle strobe at x=0, y=0
- o_frame_count  out  FRAME_W  completed-frame counter
- o_red, o_green, o_blue  out  1  test pattern (see Optional Feature)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Elaboration error if any parameter is < 1, or if H_TOTAL or V_TOTAL > 2**CW.
- Reset (async assert, sync release):
  - internal counters h=0, v=0
  - o_de=0, o_x=0, o_y=0, strobes=0, o_frame_count=0
  - syncs at inactive level (~POL)
  - RGB=0
- Each rising edge with i_enable=1:
  - output registers load the decode of the current (h,v).
  - h then advances: h=H_TOTAL-1 wraps to 0 and advances v; v=V_TOTAL-1 wraps to 0.
- Alignment and latency:
  - First enabled edge after reset presents (0,0): o_de=1, both strobes=1.
  - All outputs are mutually aligned with one-cycle latency from the counters. No combinational path from input to output.
- Decode:
  - de = (h<H_ACTIVE) && (v<V_ACTIVE)
  - hsync active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vsync active when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for the whole of those lines
- Strobes: line_start = (h==0); frame_start = (h==0 && v==0).
- o_frame_count increments in the same edge that wraps v to 0. It wraps modulo 2**FRAME_W.
- i_enable=0:
  - counters and all outputs hold, including strobes; a held strobe stays high.
  - Resuming continues with no skipped position.
- Reset mid-frame: immediate return to reset values; next frame restarts at (0,0).
- No state machine beyond the two wrap counters. The widest compare is at most CW bits; the pipeline is a single register stage.

Optional Feature:
- Macro: VGA_TESTPATTERN_EN.
- Defined: a quadrant pattern, registered in the same stage as o_de so it stays aligned:
  - o_red = de
  - o_green = de && h < H_ACTIVE/2
  - o_blue = de && v < V_ACTIVE/2
- Undefined: o_red/o_green/o_blue tied 0; no pattern logic synthesised.

Decomposition:
- Package vga_timing_pkg holds:
  - mode constants for 640x480@60 (800/525 totals) and 800x600@60 (1056/628 totals)
  - the H_TOTAL/V_TOTAL helper function
  - sync polarity constants POL_POS=1, POL_NEG=0
- One natural sub-module, vga_axis_counter, instantiated twice (h and v):
  - parameters ACTIVE/FP/SYNC/BP/CW
  - inputs: i_step, plus clock and reset
  - outputs: count, wrap, active, sync_active

Test Plan:
- Small mode H=8/2/3/1 (H_TOTAL 14), V=4/1/2/1 (V_TOTAL 8), both polarities positive, i_enable=1 → o_de high for exactly 32 cycles per frame; frame period 112 cycles; o_frame_start every 112 cycles, first on edge 1 after reset release.
- Same mode → o_hsync high exactly for o_x=10,11,12 each line; o_vsync high for the full 28 cycles with o_y=5,6; o_line_start every 14 cycles.
- H_SYNC_POL=0, V_SYNC_POL=0 → syncs low only in the windows above; during reset both are 1.
- Toggle i_enable low for 5 cycles at o_x=3, o_y=2 → all outputs frozen; on resume the next value is o_x=4, no position skipped.
- FRAME_W=2, run 5 frames → o_frame_count sequence 1,2,3,0,1, each increment coincident with o_frame_start.
- Assert i_reset_n low at o_x=9, o_y=3 → outputs reset asynchronously, before the next edge; after release the first enabled edge gives o_x=0, o_y=0. With VGA_TESTPATTERN_EN, RGB=111 at (0,0), 100 at (4,2), 000 at (9,0).
